// File: rtl/wb_pkg.sv
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, source indices and holding-entry type for the
//               register write-back collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_MEM = 1'b1;

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/reg_writeback_if.sv
// ============================================================================
// Module      : reg_writeback_if
// Description : Result handshakes, register-file write port, pending mask and
//               forwarding query of the write-back collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_writeback_if #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_rd;
    logic [DATA_W-1:0]      alu_data;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_W-1:0]      mem_rd;
    logic [DATA_W-1:0]      mem_data;
    logic                   wea;
    logic [ADDR_W-1:0]      addra;
    logic [DATA_W-1:0]      dina;
    logic [2**ADDR_W-1:0]   pending_mask;
    logic                   busy;
    logic [ADDR_W-1:0]      fwd_addr;
    logic                   fwd_hit;
    logic [DATA_W-1:0]      fwd_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output fwd_addr,
        input  alu_ready, mem_ready,
        input  wea, addra, dina, pending_mask, busy,
        input  fwd_hit, fwd_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  fwd_addr,
        output alu_ready, mem_ready,
        output wea, addra, dina, pending_mask, busy,
        output fwd_hit, fwd_data
    );

endinterface

`default_nettype wire

// File: rtl/wb_hold_slot.sv
// ============================================================================
// Module      : wb_hold_slot
// Description : One-entry holding register for a result source; accepts a new
//               result whenever empty or being retired this cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_hold_slot #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_valid,
    input  wire logic [ADDR_W-1:0] i_rd,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_grant,
    output logic                   o_ready,
    output logic                   o_v,
    output logic [ADDR_W-1:0]      o_rd,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_nxt_v,
    output logic [ADDR_W-1:0]      o_nxt_rd
);

    logic              r_v;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic              w_xfer;

    // Ready depends only on state and grant, never on i_valid.
    assign o_ready  = !r_v || i_grant;
    assign w_xfer   = i_valid && o_ready;
    assign o_nxt_v  = w_xfer || (r_v && !i_grant);
    assign o_nxt_rd = w_xfer ? i_rd : r_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v    <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
        end else begin
            r_v <= o_nxt_v;
            if (w_xfer) begin
                r_rd   <= i_rd;
                r_data <= i_data;
            end
        end
    end

    assign o_v    = r_v;
    assign o_rd   = r_rd;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/reg_writeback.sv
// ============================================================================
// Module      : reg_writeback
// Description : Round-robin write-back of ALU and load results onto a
//               registered register-file write port, with pending mask.
//               Define REG_WRITEBACK_FWD_EN to build combinational forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_writeback #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input wire logic        clka,
    input wire logic        rstb,
    reg_writeback_if.slave  bus
);
    import wb_pkg::*;

    localparam int NREG = 2**ADDR_W;

    logic              w_alu_ready, w_mem_ready;
    logic              w_alu_v, w_mem_v;
    logic [ADDR_W-1:0] w_alu_rd, w_mem_rd;
    logic [DATA_W-1:0] w_alu_data, w_mem_data;
    logic              w_alu_nv, w_mem_nv;
    logic [ADDR_W-1:0] w_alu_nrd, w_mem_nrd;
    logic              w_alu_grant, w_mem_grant, w_any_grant;
    logic [ADDR_W-1:0] w_sel_rd;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_wea_nxt;
    logic [ADDR_W-1:0] w_addra_nxt;
    logic [NREG-1:0]   w_mask_nxt;
    logic              w_busy_nxt;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    logic              r_rr_last;
    logic              r_wea;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;
    logic [NREG-1:0]   r_pending;
    logic              r_busy;

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_alu_slot (
        .clk      (clka),
        .rst      (rstb),
        .i_valid  (bus.alu_valid),
        .i_rd     (bus.alu_rd),
        .i_data   (bus.alu_data),
        .i_grant  (w_alu_grant),
        .o_ready  (w_alu_ready),
        .o_v      (w_alu_v),
        .o_rd     (w_alu_rd),
        .o_data   (w_alu_data),
        .o_nxt_v  (w_alu_nv),
        .o_nxt_rd (w_alu_nrd)
    );

    wb_hold_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem_slot (
        .clk      (clka),
        .rst      (rstb),
        .i_valid  (bus.mem_valid),
        .i_rd     (bus.mem_rd),
        .i_data   (bus.mem_data),
        .i_grant  (w_mem_grant),
        .o_ready  (w_mem_ready),
        .o_v      (w_mem_v),
        .o_rd     (w_mem_rd),
        .o_data   (w_mem_data),
        .o_nxt_v  (w_mem_nv),
        .o_nxt_rd (w_mem_nrd)
    );

    // Ties go to whichever source was not granted last; rr_last resets to ALU.
    always_comb begin
        w_alu_grant = 1'b0;
        w_mem_grant = 1'b0;
        if (w_alu_v && w_mem_v) begin
            if (r_rr_last == SRC_ALU) w_mem_grant = 1'b1;
            else                      w_alu_grant = 1'b1;
        end else begin
            w_alu_grant = w_alu_v;
            w_mem_grant = w_mem_v;
        end
    end

    assign w_any_grant = w_alu_grant || w_mem_grant;
    assign w_sel_rd    = w_mem_grant ? w_mem_rd   : w_alu_rd;
    assign w_sel_data  = w_mem_grant ? w_mem_data : w_alu_data;
    assign w_wea_nxt   = w_any_grant && (w_sel_rd != '0);
    assign w_addra_nxt = w_wea_nxt ? w_sel_rd : r_addra;

    // Mask and busy are registered from next-state values so they stay glitch-free.
    always_comb begin
        w_mask_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            w_mask_nxt[i] = (w_alu_nv  && (w_alu_nrd   == ADDR_W'(i))) ||
                            (w_mem_nv  && (w_mem_nrd   == ADDR_W'(i))) ||
                            (w_wea_nxt && (w_addra_nxt == ADDR_W'(i)));
        end
    end

    assign w_busy_nxt = w_alu_nv || w_mem_nv || w_wea_nxt;

    always_ff @(posedge clka) begin
        if (rstb) begin
            r_rr_last <= SRC_ALU;
            r_wea     <= 1'b0;
            r_addra   <= '0;
            r_dina    <= '0;
            r_pending <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_any_grant) begin
                r_rr_last <= w_mem_grant ? SRC_MEM : SRC_ALU;
            end
            r_wea <= w_wea_nxt;
            if (w_wea_nxt) begin
                r_addra <= w_sel_rd;
                r_dina  <= w_sel_data;
            end
            r_pending <= w_mask_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

`ifdef REG_WRITEBACK_FWD_EN
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        if (bus.fwd_addr != '0) begin
            if (w_mem_v && (w_mem_rd == bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_mem_data;
            end else if (w_alu_v && (w_alu_rd == bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = w_alu_data;
            end else if (r_wea && (r_addra == bus.fwd_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_dina;
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^bus.fwd_addr;
    assign w_fwd_hit    = 1'b0;
    assign w_fwd_data   = '0;
`endif

    assign bus.alu_ready    = w_alu_ready;
    assign bus.mem_ready    = w_mem_ready;
    assign bus.wea          = r_wea;
    assign bus.addra        = r_addra;
    assign bus.dina         = r_dina;
    assign bus.pending_mask = r_pending;
    assign bus.busy         = r_busy;
    assign bus.fwd_hit      = w_fwd_hit;
    assign bus.fwd_data     = w_fwd_data;

endmodule

`default_nettype wire

// File: tb/tb_reg_writeback.sv
// ============================================================================
// Module      : tb_reg_writeback
// Description : Directed and random checks of reg_writeback against a
//               cycle-level reference model of the write-back rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_writeback;
    import wb_pkg::*;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 2**AW;

    logic clka = 1'b0;
    logic rstb;
    int   total = 0;
    int   bad   = 0;

    reg_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clka (clka),
        .rstb (rstb),
        .bus  (bus)
    );

    always #5 clka = ~clka;

    // Reference model: index 0 = ALU, 1 = MEM.
    wb_entry_t         m_ent [2];
    int                m_last;
    logic              m_wea;
    logic [AW-1:0]     m_addra;
    logic [DW-1:0]     m_dina;
    logic              prev_alu_low, prev_mem_low;
    logic [AW-1:0]     wr_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) m_ent[s] = '0;
        m_last  = 0;
        m_wea   = 1'b0;
        m_addra = '0;
        m_dina  = '0;
        prev_alu_low = 1'b0;
        prev_mem_low = 1'b0;
    endtask

    function automatic int model_grant();
        if (m_ent[0].v && m_ent[1].v) return (m_last == 0) ? 1 : 0;
        if (m_ent[0].v) return 0;
        if (m_ent[1].v) return 1;
        return -1;
    endfunction

    task automatic check_outputs();
        int            g;
        logic [NREG-1:0] em;
        logic          eh;
        logic [DW-1:0] ed;
        g  = model_grant();
        em = '0;
        for (int s = 0; s < 2; s++)
            if (m_ent[s].v && m_ent[s].rd != 0) em[m_ent[s].rd] = 1'b1;
        if (m_wea && m_addra != 0) em[m_addra] = 1'b1;
        eh = 1'b0;
        ed = '0;
`ifdef REG_WRITEBACK_FWD_EN
        if (bus.fwd_addr != 0) begin
            if (m_ent[1].v && m_ent[1].rd == bus.fwd_addr) begin eh = 1; ed = m_ent[1].data; end
            else if (m_ent[0].v && m_ent[0].rd == bus.fwd_addr) begin eh = 1; ed = m_ent[0].data; end
            else if (m_wea && m_addra == bus.fwd_addr) begin eh = 1; ed = m_dina; end
        end
`endif
        chk("alu_ready", bus.alu_ready, (!m_ent[0].v || g == 0));
        chk("mem_ready", bus.mem_ready, (!m_ent[1].v || g == 1));
        chk("wea", bus.wea, m_wea);
        chk("addra", bus.addra, m_addra);
        chk("dina", bus.dina, m_dina);
        chk("pending_mask", bus.pending_mask, em);
        chk("busy", bus.busy, (m_ent[0].v || m_ent[1].v || m_wea));
        chk("fwd_hit", bus.fwd_hit, eh);
        chk("fwd_data", bus.fwd_data, ed);
        chk("alu_ready_not_low_twice", !(prev_alu_low && !bus.alu_ready), 1'b1);
        chk("mem_ready_not_low_twice", !(prev_mem_low && !bus.mem_ready), 1'b1);
        prev_alu_low = !bus.alu_ready;
        prev_mem_low = !bus.mem_ready;
    endtask

    // One clock: check mid-cycle, advance model with the applied inputs, step past the edge.
    task automatic tick();
        int   g;
        logic rdy [2];
        logic vin [2];
        #4;
        check_outputs();
        g      = model_grant();
        rdy[0] = !m_ent[0].v || g == 0;
        rdy[1] = !m_ent[1].v || g == 1;
        vin[0] = bus.alu_valid;
        vin[1] = bus.mem_valid;
        if (rstb) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                m_last = g;
                m_wea  = (m_ent[g].rd != 0);
                if (m_ent[g].rd != 0) begin
                    m_addra = m_ent[g].rd;
                    m_dina  = m_ent[g].data;
                end
                m_ent[g].v = 1'b0;
            end else begin
                m_wea = 1'b0;
            end
            if (vin[0] && rdy[0]) m_ent[0] = '{v: 1'b1, rd: bus.alu_rd, data: bus.alu_data};
            if (vin[1] && rdy[1]) m_ent[1] = '{v: 1'b1, rd: bus.mem_rd, data: bus.mem_data};
        end
        @(posedge clka);
        #1;
        if (bus.wea) wr_log.push_back(bus.addra);
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.mem_valid = 1'b0;
    endtask

    initial begin
        int             ai, mi;
        logic [AW-1:0]  exp_rd;
        logic           exp_hit;
        logic [DW-1:0]  exp_dat;

        rstb = 1'b1;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.fwd_addr  = '0;
        repeat (2) @(posedge clka);
        #1;
        model_reset();
        rstb = 1'b0;

        // Single ALU result: rd=3.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hDEADBEEF;
        tick();
        idle();
        chk("t2_mask_held", bus.pending_mask, 32'h8);
        tick();
        chk("t2_wea", bus.wea, 1'b1);
        chk("t2_addra", bus.addra, 5'd3);
        chk("t2_dina", bus.dina, 32'hDEADBEEF);
        chk("t2_mask_out", bus.pending_mask, 32'h8);
        tick();
        chk("t2_wea_low", bus.wea, 1'b0);
        chk("t2_mask_clear", bus.pending_mask, 32'h0);

        // Continuous contention: offers advance only on acceptance.
        wr_log.delete();
        ai = 0; mi = 0;
        for (int c = 0; c < 8; c++) begin
            bus.alu_valid = 1'b1; bus.alu_rd = AW'(1 + ai);  bus.alu_data = $urandom;
            bus.mem_valid = 1'b1; bus.mem_rd = AW'(17 + mi); bus.mem_data = $urandom;
            #1;
            if (bus.alu_ready) ai++;
            if (bus.mem_ready) mi++;
            tick();
        end
        idle();
        repeat (4) tick();
        chk("t3_write_count", wr_log.size(), 9);
        for (int k = 0; k < 9 && k < wr_log.size(); k++) begin
            exp_rd = (k % 2 == 0) ? AW'(17 + k / 2) : AW'(1 + k / 2);
            chk("t3_write_order", wr_log[k], exp_rd);
        end

        // rd=0 is consumed without a write.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h12345678;
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            chk("t4_mask_bit0", bus.pending_mask[0], 1'b0);
            tick();
            chk("t4_wea", bus.wea, 1'b0);
        end

        // Reset while both slots are full and a write is in flight.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h7;
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd9; bus.mem_data = 32'h9;
        tick();
        bus.alu_rd = 5'd8; bus.mem_rd = 5'd10;
        tick();
        chk("t5_wea_before", bus.wea, 1'b1);
        chk("t5_busy_before", bus.busy, 1'b1);
        rstb = 1'b1;
        idle();
        tick();
        rstb = 1'b0;
        chk("t5_wea", bus.wea, 1'b0);
        chk("t5_mask", bus.pending_mask, 32'h0);
        chk("t5_busy", bus.busy, 1'b0);
        chk("t5_alu_ready", bus.alu_ready, 1'b1);
        chk("t5_mem_ready", bus.mem_ready, 1'b1);
        tick();

        // Forwarding priority: mem slot beats the output stage.
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd5; bus.mem_data = 32'hBB;
        tick();
        bus.mem_data = 32'hAA;
        tick();
        idle();
        bus.fwd_addr = 5'd5;
        #1;
`ifdef REG_WRITEBACK_FWD_EN
        exp_hit = 1'b1; exp_dat = 32'hAA;
`else
        exp_hit = 1'b0; exp_dat = 32'h0;
`endif
        chk("t6_fwd_hit", bus.fwd_hit, exp_hit);
        chk("t6_fwd_data", bus.fwd_data, exp_dat);
        tick();
        repeat (2) tick();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            rstb          = ($urandom_range(63) == 0);
            bus.alu_valid = $urandom_range(1);
            bus.mem_valid = $urandom_range(1);
            bus.alu_rd    = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
            bus.mem_rd    = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
            bus.alu_data  = $urandom;
            bus.mem_data  = $urandom;
            bus.fwd_addr  = AW'($urandom);
            tick();
        end
        rstb = 1'b0;
        idle();
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
